// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared constants and types for the 1-to-8 frame demultiplexer.
//   NUM_LANES : number of output lanes / data bits per frame
//   SEL_W     : width of the slot index
//   state_t   : frame FSM states (S_PAR only reachable with parity compiled in)
// ---------------------------------------------------------------------------
package demux_pkg;

    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;

    typedef enum logic {
        S_DATA = 1'b0,
        S_PAR  = 1'b1
    } state_t;

endpackage

// File: rtl/demux_1by8_frame_if.sv
// ---------------------------------------------------------------------------
// demux_1by8_frame_if
// Serial-in / frame-out bundle of the 1-to-8 frame demultiplexer.
//   master : drives d_in, d_valid, sync; observes the demux outputs
//   slave  : the demux itself
// Signals:
//   d_in        serial data bit
//   d_valid     d_in carries a slot bit this cycle
//   sync        restart the frame; next accepted bit is slot 0
//   Y           per-lane holding register (Y[k] = last bit accepted in slot k)
//   s           slot index the next accepted data bit will fill
//   frame       last completed frame, bit k = slot k
//   frame_valid one-cycle strobe, frame updated this cycle
//   frame_err   parity error flag, meaningful with frame_valid
// ---------------------------------------------------------------------------
interface demux_1by8_frame_if;
    import demux_pkg::*;

    logic                 d_in;
    logic                 d_valid;
    logic                 sync;
    logic [NUM_LANES-1:0] Y;
    logic [SEL_W-1:0]     s;
    logic [NUM_LANES-1:0] frame;
    logic                 frame_valid;
    logic                 frame_err;

    modport master (
        output d_in, d_valid, sync,
        input  Y, s, frame, frame_valid, frame_err
    );

    modport slave (
        input  d_in, d_valid, sync,
        output Y, s, frame, frame_valid, frame_err
    );

endinterface

// File: rtl/demux_slot_ctr.sv
// ---------------------------------------------------------------------------
// demux_slot_ctr
// Slot counter for the frame demultiplexer.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart at slot 0 (sync)
//   en       : a data bit is accepted this cycle
//   slot     : slot index the next accepted data bit will fill
//   term     : slot == last lane
// ---------------------------------------------------------------------------
module demux_slot_ctr
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [SEL_W-1:0] slot,
    output logic             term
);

    logic [SEL_W-1:0] slot_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_reg <= '0;
        end else if (clr) begin
            // A bit arriving together with sync is slot 0, so the next one is slot 1.
            slot_reg <= en ? SEL_W'(1) : '0;
        end else if (en) begin
            slot_reg <= slot_reg + SEL_W'(1);
        end
    end

    assign slot = slot_reg;
    assign term = (slot_reg == SEL_W'(NUM_LANES - 1));

endmodule

// File: rtl/demux_1by8_frame.sv
// ---------------------------------------------------------------------------
// demux_1by8_frame
// Registered 1-to-8 demultiplexer: steers serial slot bits onto 8 lanes and
// publishes each completed 8-bit frame with a one-cycle strobe.
// Build option:
//   DEMUX_PARITY_EN  defined   -> a trailing parity bit follows every 8 data
//                                 bits (S_PAR state), frame_err is live.
//                    undefined -> 8-bit frames, frame_err tied to 0.
// Parameters:
//   PAR_ODD : parity sense with parity compiled in (0 = even, 1 = odd)
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : demux_1by8_frame_if.slave (serial input, lanes, frame outputs)
// ---------------------------------------------------------------------------
module demux_1by8_frame
    import demux_pkg::*;
#(
    parameter bit PAR_ODD = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    demux_1by8_frame_if.slave  bus
);

    state_t               state_reg;
    logic [NUM_LANES-1:0] y_reg;
    logic [NUM_LANES-1:0] frame_reg;
    logic                 frame_valid_reg;
    logic [SEL_W-1:0]     slot;
    logic                 slot_term;
    logic                 accept_data;
    logic [SEL_W-1:0]     lane_sel;
    logic [NUM_LANES-1:0] assembled;

    // sync forces S_DATA, so a bit arriving with sync is always a data bit.
    assign accept_data = bus.d_valid && (bus.sync || (state_reg == S_DATA));
    assign lane_sel    = bus.sync ? '0 : slot;
    // Byte as it stands once the slot-7 bit lands this cycle.
    assign assembled   = {bus.d_in, y_reg[NUM_LANES-2:0]};

    demux_slot_ctr u_slot_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.sync),
        .en   (accept_data),
        .slot (slot),
        .term (slot_term)
    );

    // Lane holding registers; lanes of a discarded partial frame keep their bits.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    y_reg[gi] <= 1'b0;
                end else if (accept_data && (lane_sel == SEL_W'(gi))) begin
                    y_reg[gi] <= bus.d_in;
                end
            end
        end
    endgenerate

`ifdef DEMUX_PARITY_EN
    logic [NUM_LANES-1:0] byte_reg;
    logic                 frame_err_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_DATA;
            frame_reg       <= '0;
            frame_valid_reg <= 1'b0;
`ifdef DEMUX_PARITY_EN
            byte_reg        <= '0;
            frame_err_reg   <= 1'b0;
`endif
        end else begin
            frame_valid_reg <= 1'b0;
            if (bus.sync) begin
                // Restart discards any partial frame, including one awaiting parity.
                state_reg <= S_DATA;
            end else if (bus.d_valid) begin
                case (state_reg)
                    S_DATA: begin
                        if (slot_term) begin
`ifdef DEMUX_PARITY_EN
                            byte_reg  <= assembled;
                            state_reg <= S_PAR;
`else
                            frame_reg       <= assembled;
                            frame_valid_reg <= 1'b1;
`endif
                        end
                    end
`ifdef DEMUX_PARITY_EN
                    S_PAR: begin
                        frame_reg       <= byte_reg;
                        frame_err_reg   <= (^byte_reg) ^ bus.d_in ^ PAR_ODD;
                        frame_valid_reg <= 1'b1;
                        state_reg       <= S_DATA;
                    end
`endif
                    default: state_reg <= S_DATA;
                endcase
            end
        end
    end

    assign bus.Y           = y_reg;
    assign bus.s           = slot;
    assign bus.frame       = frame_reg;
    assign bus.frame_valid = frame_valid_reg;
`ifdef DEMUX_PARITY_EN
    assign bus.frame_err   = frame_err_reg;
`else
    // No parity stage: the flag is constant and the parity sense has no effect.
    assign bus.frame_err   = 1'b0 & PAR_ODD;
`endif

endmodule

// File: doc/demux_1by8_frame.md
# demux_1by8_frame

Registered 1-to-8 demultiplexer that reassembles serial bit slots, as produced by an 8:1 mux swept over select 0..7, back into 8-bit frames. An internal slot counter steers each valid input bit to lane i[slot], publishes a completed frame with a one-cycle strobe, and optionally checks a trailing parity bit. It sits at the receive end of the mux-based serial link in the combinational-logic library.

## Interface
- PAR_ODD, default 0: parity sense when parity is compiled in; 0 = even, 1 = odd. Ignored otherwise.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- d_in  in  1  serial data bit
- d_valid  in  1  d_in is a valid slot bit this cycle
- sync  in  1  restart frame; next accepted bit is slot 0
- Y  out  8  per-lane holding register; Y[k] is the last bit accepted in slot k
- s  out  3  slot index the next accepted data bit will fill
- frame  out  8  last completed frame, bit k = slot k
- frame_valid  out  1  one-cycle strobe: frame updated this cycle
- frame_err  out  1  parity error flag, valid with frame_valid; constant 0 without parity

## Operation
- Reset values: Y=8'h00, s=3'd0, frame=8'h00, frame_valid=0, frame_err=0, state=S_DATA.
- States: S_DATA (collecting slots 0..7), S_PAR (waiting for parity bit; exists only with parity compiled in).
- S_DATA, d_valid=1: Y[s]<=d_in, s<=s+1 (3-bit wrap).
  - s==7 without parity: frame<={d_in,Y[6:0]}, frame_valid<=1, s<=0, stay in S_DATA.
  - s==7 with parity: latch the assembled byte internally, go to S_PAR, s wraps to 0.
- S_PAR, d_valid=1: frame<=latched byte, frame_err<=(^byte ^ d_in ^ PAR_ODD), frame_valid<=1, go to S_DATA. Y is not written in S_PAR.
- d_valid=0: no state change; frame_valid deasserts.
- sync=1: s<=0, state<=S_DATA, discard any partial frame (no frame_valid). If d_valid=1 in the same cycle, the bit is accepted as slot 0 (Y[0]<=d_in, s<=1).
- sync is never a completion: sync while s==7 or in S_PAR produces no frame_valid.
- Y lanes from a discarded partial frame keep their values; only frame is gated by completion.
- frame_err is updated only on frame_valid and holds otherwise.

## Timing
- Every output is registered, with no combinational path from input to output.
- Lane latency: bit accepted at edge N appears on Y[k] after edge N.
- Frame latency: frame and frame_valid update at the edge accepting slot 7 (no parity) or the parity bit (parity). frame_valid is high for exactly that one cycle.
- Throughput: one bit per clock. Back-to-back frames give frame_valid every 8 cycles (9 with parity).
- d_valid may drop at any slot. The frame resumes at the held s.
- rst asserted mid-frame clears all state immediately (asynchronous). The first bit after release is slot 0.

## Configuration
- DEMUX_PARITY_EN defined: S_PAR state compiled in. Each frame is 9 accepted bits (8 data plus parity) and frame_err is live.
- DEMUX_PARITY_EN undefined: 8-bit frames, S_PAR absent, and frame_err tied to 0.

## Structure
- Shared package demux_pkg holds:
  - NUM_LANES=8 and SEL_W=3.
  - State enum {S_DATA, S_PAR}.
- One sub-module: demux_slot_ctr, a 3-bit counter with clear (sync), enable (accepted data bit) and terminal flag (s==7). The top block holds the lanes, the frame register and the FSM.

## Test plan
- Reset, then 8 valid bits 1,0,1,1,0,0,1,0 (slot 0 first) -> frame=8'h4D with frame_valid high one cycle after the 8th bit; s back to 0; Y=8'h4D.
- d_valid gaps: same 8 bits with d_valid low 2 cycles after slots 2 and 5 -> frame=8'h4D, exactly one frame_valid, s held during gaps.
- sync after 5 bits, then 8 bits all 1 -> no frame_valid for the partial frame; frame=8'hFF. Repeat with sync coincident with the first bit of the new frame -> that bit lands in Y[0] and s=1.
- rst pulsed asynchronously (mid-cycle) after 4 bits -> all outputs 0 immediately; next 8 bits produce a clean frame.
- DEMUX_PARITY_EN, PAR_ODD=0: data 8'hA5 then parity 0 -> frame=8'hA5, frame_err=0. With parity 1 -> frame_err=1. No frame_valid after the 8th bit.
- 3 back-to-back frames 8'h01, 8'h80, 8'hFF -> frame_valid at cycles 8, 16 and 24 (9, 18 and 27 with parity), with matching frame values.
